// File: rtl/ysyx_23060201_ifu.sv
// ysyx_23060201_ifu: multi-cycle instruction fetch unit.
// Owns the PC, fetches over a valid/ready memory handshake, hands words to the
// IDU over a second valid/ready handshake and absorbs EXU redirects at any time.
// Optional feature: define YSYX_23060201_IFU_ALIGN_CHK_EN to trap misaligned
// fetch PCs in a FAULT state instead of issuing them to memory.
module ysyx_23060201_ifu #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    output logic            imem_rsp_ready,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] fetch_cnt,
    output logic            fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] pc, pc_nx;
    logic            drop, drop_nx;
    logic            pend_v, pend_v_nx;
    logic [XLEN-1:0] pend_pc, pend_pc_nx;
    logic [31:0]     inst_nx;
    logic [XLEN-1:0] inst_pc_nx;
    logic [XLEN-1:0] fetch_cnt_nx;
    logic            go_req;

    // Outputs decode from state/registers only
    assign imem_req_valid = (state == S_REQ);
    assign imem_rsp_ready = (state == S_WAIT);
    assign inst_valid     = (state == S_HOLD);
    assign imem_req_addr  = pc;
`ifdef YSYX_23060201_IFU_ALIGN_CHK_EN
    assign fault          = (state == S_FAULT);
`else
    assign fault          = 1'b0;
`endif

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            pend_v    <= 1'b0;
            pend_pc   <= '0;
            inst      <= '0;
            inst_pc   <= RESET_PC;
            fetch_cnt <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            drop      <= drop_nx;
            pend_v    <= pend_v_nx;
            pend_pc   <= pend_pc_nx;
            inst      <= inst_nx;
            inst_pc   <= inst_pc_nx;
            fetch_cnt <= fetch_cnt_nx;
        end
    end

    // Next-state, PC update and redirect bookkeeping
    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        drop_nx      = drop;
        pend_v_nx    = pend_v;
        pend_pc_nx   = pend_pc;
        inst_nx      = inst;
        inst_pc_nx   = inst_pc;
        fetch_cnt_nx = fetch_cnt;
        go_req       = 1'b0;

        case (state)
            S_IDLE: begin
                if (redirect_valid) pc_nx = redirect_pc;
                go_req = 1'b1;
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    state_nx  = S_WAIT;
                    pend_v_nx = 1'b0;
                    // The accepted fetch is for the old PC; retarget and drop its response
                    if (redirect_valid) begin
                        drop_nx = 1'b1;
                        pc_nx   = redirect_pc;
                    end else if (pend_v) begin
                        drop_nx = 1'b1;
                        pc_nx   = pend_pc;
                    end
                end else if (redirect_valid) begin
                    // Address must not move before acceptance: park the target
                    pend_v_nx  = 1'b1;
                    pend_pc_nx = redirect_pc;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_nx = redirect_pc;
                    // A response in this same cycle closes the stale fetch itself,
                    // so no drop is left armed for the next one
                    if (imem_rsp_valid) begin
                        drop_nx = 1'b0;
                        go_req  = 1'b1;
                    end else begin
                        drop_nx = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop) begin
                        drop_nx = 1'b0;
                        go_req  = 1'b1;
                    end else begin
                        inst_nx    = imem_rsp_data;
                        inst_pc_nx = pc;
                        state_nx   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (inst_ready) fetch_cnt_nx = fetch_cnt + XLEN'(1);
                if (redirect_valid) begin
                    pc_nx  = redirect_pc;
                    go_req = 1'b1;
                end else if (inst_ready) begin
                    pc_nx  = pc + XLEN'(4);
                    go_req = 1'b1;
                end
            end
            S_FAULT: begin
`ifdef YSYX_23060201_IFU_ALIGN_CHK_EN
                if (redirect_valid) begin
                    pc_nx  = redirect_pc;
                    go_req = 1'b1;
                end
`else
                state_nx = S_IDLE;
`endif
            end
            default: state_nx = S_IDLE;
        endcase

        // Every entry into REQ funnels through here so the alignment check sees the new PC
        if (go_req) begin
            state_nx = S_REQ;
`ifdef YSYX_23060201_IFU_ALIGN_CHK_EN
            if (pc_nx[1:0] != 2'b00) state_nx = S_FAULT;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// tb_ysyx_23060201_ifu: randomized scoreboard bench for the fetch unit with a
// latency-configurable memory model and an architectural PC reference.
module tb_ysyx_23060201_ifu;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid, imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_cnt;
    logic        fault;

    ysyx_23060201_ifu #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
        .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_cnt(fetch_cnt), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] expq[$];
    logic [31:0] arch;

    // memory / IDU model state
    bit          busy, p_req_hs, p_rsp_hs, p_rst, spur_en;
    logic [31:0] out_addr, p_addr;
    int unsigned reqwait, rspwait, rdelay, sdelay, rmin, rmax, smin, smax, stall;
    int unsigned idu_mode;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: latch handshakes of the ending cycle, then drive memory and IDU for the next
    task automatic tick();
        p_rst    = rst;
        p_req_hs = imem_req_valid && imem_req_ready;
        p_rsp_hs = imem_rsp_valid && imem_rsp_ready;
        p_addr   = imem_req_addr;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (p_rst) begin
            busy    = 1'b0;
            reqwait = 0;
            rdelay  = $urandom_range(rmax, rmin);
        end else begin
            if (p_rsp_hs) busy = 1'b0;
            if (p_req_hs) begin
                busy     = 1'b1;
                out_addr = p_addr;
                rspwait  = 0;
                sdelay   = $urandom_range(smax, smin);
                reqwait  = 0;
                rdelay   = $urandom_range(rmax, rmin);
            end
        end
        if (imem_req_valid) begin
            imem_req_ready = (reqwait >= rdelay);
            reqwait++;
        end else begin
            imem_req_ready = 1'b0;
            reqwait = 0;
        end
        if (busy) begin
            imem_rsp_valid = (rspwait >= sdelay);
            imem_rsp_data  = imem_rsp_valid ? mdata(out_addr) : $urandom;
            rspwait++;
        end else begin
            imem_rsp_valid = spur_en && ($urandom_range(3, 0) == 0);
            imem_rsp_data  = $urandom;
        end
        case (idu_mode)
            0: inst_ready = 1'b1;
            1: inst_ready = 1'($urandom_range(1, 0));
            default: begin
                if (inst_valid) begin
                    inst_ready = (stall >= 3);
                    stall++;
                end else begin
                    inst_ready = 1'b0;
                    stall = 0;
                end
            end
        endcase
    endtask

    // Reference: architectural next-PC, advanced by consumed instructions and overridden by redirects
    always @(negedge clk) begin
        #1;
        if (rst) begin
            arch = RPC;
            expq.delete();
            expq.push_back(arch);
        end else if ((inst_valid && inst_ready) || redirect_valid) begin
            if (inst_valid && inst_ready) arch = arch + 32'd4;
            if (redirect_valid) arch = redirect_pc;
            expq.delete();
            expq.push_back(arch);
        end
    end

    // Monitor: compares every IDU handshake against the scoreboard, plus hold/stability rules
    logic [31:0] mcnt, pa, pi, pipc, e;
    bit          pv_req, pv_inst;
    always @(negedge clk) begin
        if (rst) begin
            mcnt    = '0;
            pv_req  = 1'b0;
            pv_inst = 1'b0;
        end else begin
            if (pv_req) begin
                chk("req_held", 32'(imem_req_valid), 32'd1);
                chk("req_addr_stable", imem_req_addr, pa);
            end
            if (pv_inst) begin
                chk("inst_valid_held", 32'(inst_valid), 32'd1);
                chk("inst_stable", inst, pi);
                chk("inst_pc_stable", inst_pc, pipc);
            end
            if (inst_valid && inst_ready) begin
                chk("sb_has_entry", 32'(expq.size()), 32'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("inst_pc", inst_pc, e);
                    chk("inst_data", inst, mdata(e));
                    chk("fetch_cnt", fetch_cnt, mcnt);
                end
                mcnt = mcnt + 32'd1;
            end
            pv_req  = imem_req_valid && !imem_req_ready;
            pa      = imem_req_addr;
            pv_inst = inst_valid && !inst_ready && !redirect_valid;
            pi      = inst;
            pipc    = inst_pc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] cnt0, r;
    int unsigned n;

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
        rmin = 0; rmax = 0; smin = 0; smax = 0; idu_mode = 0; spur_en = 1'b0;
        busy = 1'b0; reqwait = 0; rspwait = 0; rdelay = 0; sdelay = 0; stall = 0; out_addr = '0;

        // reset values
        repeat (3) tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, RPC);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_req_addr", imem_req_addr, RPC);
        rst = 1'b0;

        // zero-wait latency: cycle 0 is IDLE
        tick();
        chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c1_req_addr", imem_req_addr, RPC);
        tick();
        chk("c2_inst_valid", 32'(inst_valid), 32'd0);
        chk("c2_rsp_ready", 32'(imem_rsp_ready), 32'd1);
        tick();
        chk("c3_inst_valid", 32'(inst_valid), 32'd1);
        n = 0;
        while (fetch_cnt != 32'd3 && n < 40) begin tick(); n++; end
        chk("cnt_after_three", fetch_cnt, 32'd3);

        // slow memory and stalling IDU
        rmin = 4; rmax = 4; smin = 5; smax = 5; idu_mode = 2;
        cnt0 = fetch_cnt; n = 0;
        while (fetch_cnt != cnt0 + 32'd3 && n < 200) begin tick(); n++; end
        chk("slow_progress", fetch_cnt, cnt0 + 32'd3);

        // redirect while a response is in flight
        rmin = 0; rmax = 0; smin = 3; smax = 3; idu_mode = 0;
        n = 0;
        while (!(imem_rsp_ready && !imem_rsp_valid) && n < 100) begin tick(); n++; end
        chk("wait_state_reached", 32'(n < 100), 32'd1);
        cnt0 = fetch_cnt;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        n = 0;
        while (!imem_req_valid && n < 50) begin tick(); n++; end
        chk("rdw_req_addr", imem_req_addr, 32'h8000_0100);
        chk("rdw_cnt_unchanged", fetch_cnt, cnt0);

        // redirect in HOLD with the IDU consuming in the same cycle
        smin = 0; smax = 0;
        n = 0;
        while (!inst_valid && n < 50) begin tick(); n++; end
        cnt0 = fetch_cnt;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        tick();
        chk("rdh_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rdh_req_addr", imem_req_addr, 32'h8000_0200);
        chk("rdh_cnt", fetch_cnt, cnt0 + 32'd1);

        // PC wrap at the top of the address space
        n = 0;
        while (!inst_valid && n < 50) begin tick(); n++; end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        n = 0;
        while (!inst_valid && n < 50) begin tick(); n++; end
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        chk("wrap_req_addr", imem_req_addr, 32'h0000_0000);

        // misaligned redirect target
        n = 0;
        while (!inst_valid && n < 50) begin tick(); n++; end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        tick();
`ifdef YSYX_23060201_IFU_ALIGN_CHK_EN
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_no_req", 32'(imem_req_valid), 32'd0);
        repeat (3) tick();
        chk("mis_fault_held", 32'(fault), 32'd1);
        chk("mis_still_no_req", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0104;
        tick();
        chk("fix_fault_clear", 32'(fault), 32'd0);
        chk("fix_req_valid", 32'(imem_req_valid), 32'd1);
        chk("fix_req_addr", imem_req_addr, 32'h8000_0104);
`else
        chk("mis_fault_low", 32'(fault), 32'd0);
        chk("mis_req_valid", 32'(imem_req_valid), 32'd1);
        chk("mis_req_addr", imem_req_addr, 32'h8000_0102);
`endif

        // randomized traffic with a mid-run reset
        rmin = 0; rmax = 3; smin = 0; smax = 3; idu_mode = 1; spur_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (i == 1000) begin
                rst = 1'b1;
                tick();
                chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
                chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
                chk("mid_rst_fetch_cnt", fetch_cnt, 32'd0);
                chk("mid_rst_inst_pc", inst_pc, RPC);
                chk("mid_rst_req_addr", imem_req_addr, RPC);
                chk("mid_rst_fault", 32'(fault), 32'd0);
                rst = 1'b0;
            end else if ($urandom_range(9, 0) == 0) begin
                r = $urandom;
                redirect_valid = 1'b1;
                redirect_pc = RPC | (r & 32'h0000_0FFC);
            end
        end
        chk("random_progress", 32'(mcnt > 32'd50), 32'd1);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060201_ifu.md
# ysyx_23060201_ifu

Parametrised multi-cycle instruction fetch unit replacing the combinational PC-to-memory fetch path of the single-cycle core. It owns the PC register, issues fetch requests over a valid/ready handshake to instruction memory, tolerates arbitrary memory latency, and hands instructions to the IDU over a second valid/ready handshake. It accepts branch/jump redirects from the EXU, including redirects that arrive while a fetch is in flight.

## Interface
- `XLEN`, 32: PC and address width.
- `RESET_PC`, `MBASE` (32'h8000_0000): PC value after reset.
- `clk` input 1: core clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts the request.
- `imem_req_addr` output XLEN: fetch address; equals `pc` while `imem_req_valid` is high.
- `imem_rsp_valid` input 1: instruction word valid.
- `imem_rsp_ready` output 1: IFU accepts the response; high only in WAIT.
- `imem_rsp_data` input 32: fetched instruction.
- `inst_valid` output 1: instruction available to the IDU.
- `inst_ready` input 1: IDU consumes the instruction.
- `inst` output 32: instruction word, held stable while `inst_valid` is high.
- `inst_pc` output XLEN: PC of `inst`.
- `redirect_valid` input 1: EXU redirect strobe, one cycle.
- `redirect_pc` input XLEN: redirect target (dnpc).
- `fetch_cnt` output XLEN: count of instructions handed to the IDU.
- `fault` output 1: misaligned-fetch fault. See Configuration.

## Operation
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: entered on reset and left after one cycle, going to REQ. A redirect in IDLE loads `pc` from `redirect_pc`.
- REQ: `imem_req_valid`=1.
  - On `imem_req_ready`, go to WAIT.
  - Address must stay stable until accepted.
- WAIT: `imem_rsp_ready`=1.
  - On `imem_rsp_valid`, capture `inst`/`inst_pc` and go to HOLD.
  - If the drop flag is set, discard the response instead, clear the flag, and go to REQ.
- HOLD: `inst_valid`=1.
  - On `inst_ready`: `pc` <= `pc`+4 (modulo 2^XLEN, wraps), `fetch_cnt` increments (wraps), go to REQ.
- Redirect handling, by state:
  - REQ with `imem_req_ready` in the same cycle: the request is accepted; set the drop flag; `pc` <= `redirect_pc`; go to WAIT.
  - REQ without ready: store the target in a pending register. Keep the address stable. On accept, set the drop flag and apply the pending target to `pc`.
  - WAIT: set the drop flag; `pc` <= `redirect_pc`. A response arriving in the same cycle is discarded.
  - HOLD: `inst_valid` drops next cycle; `pc` <= `redirect_pc`; go to REQ.
    - If `inst_ready` is high in the same cycle, the instruction counts as consumed (`fetch_cnt` increments), but the redirect target wins over `pc`+4.
  - A second redirect before the first is applied: the newest target wins.
- Responses outside WAIT are ignored. `imem_rsp_ready`=0 outside WAIT.

## Timing
- Reset values:
  - `pc` = `RESET_PC`; `imem_req_addr` = `RESET_PC`.
  - `imem_req_valid`, `imem_rsp_ready`, `inst_valid`, `fault` = 0.
  - `inst` = 0; `inst_pc` = `RESET_PC`; `fetch_cnt` = 0.
  - Drop flag and pending register cleared.
- Reset mid-operation: all of the above apply on the next edge; the in-flight fetch is abandoned.
- Zero-wait memory, counting cycles from reset deassertion (cycle 0 = IDLE):
  - `imem_req_valid` rises in cycle 1.
  - `inst_valid` rises in cycle 3.
- Steady-state throughput: 1 instruction per 3 cycles (HOLD→REQ→WAIT), plus memory wait cycles.
- Redirect to new request: with a redirect in HOLD at cycle n, `imem_req_valid` with the new address is seen in cycle n+1.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Configuration
- `YSYX_23060201_IFU_ALIGN_CHK_EN`, defined:
  - On entry to REQ, if `pc[1:0]`≠0, go to FAULT instead of issuing a request; `fault`=1.
  - FAULT is left only on a redirect (`fault` clears and the next state is REQ) or on reset.
- Not defined:
  - The alignment check is not built.
  - `fault` is tied to 0.
  - Misaligned PCs are issued to memory unmodified.

## Test plan
- Reset, zero-wait memory, IDU always ready:
  - Cycle 1: `imem_req_addr` = 8000_0000.
  - Cycle 3: `inst_valid`.
  - Subsequent addresses: 8000_0004, 8000_0008; `fetch_cnt` = 3 after the third handshake.
- Memory accepts with 4-cycle ready delay and 5-cycle response delay; IDU stalls 3 cycles in HOLD:
  - `imem_req_addr` is stable while the request waits.
  - `inst` is stable while the IDU stalls.
  - No duplicate or skipped PC.
- Redirect to 8000_0100 in WAIT:
  - The in-flight response is discarded and never presented.
  - The next request address is 8000_0100.
  - `fetch_cnt` is unchanged by the dropped response.
- Redirect to 8000_0200 in HOLD, with `inst_ready` high in the same cycle:
  - The current instruction counts (`fetch_cnt` +1).
  - The next fetch is at 8000_0200, not `pc`+4.
- `pc` = FFFF_FFFC, handshake: `pc` wraps to 0000_0000.
- Macro defined, redirect to 8000_0102: `fault`=1 and no request is issued. A redirect to 8000_0104 clears `fault` and fetch resumes there. With the macro undefined, the same stimulus issues a request at 8000_0102.
